// File: rtl/rrv2rvh_ruby_ld_sched_pkg.sv
// Shared widths, load opcode encoding and the load byte-mask decoder used by the
// ruby load scheduler.
package rrv2rvh_ruby_ld_sched_pkg;

    localparam int unsigned LDU_OP_WIDTH       = 4;
    localparam int unsigned PADDR_WIDTH        = 56;
    localparam int unsigned L1D_STB_DATA_WIDTH = 512;
    localparam int unsigned L1D_MASK_WIDTH     = L1D_STB_DATA_WIDTH / 8;
    localparam int unsigned L1D_OFFSET_WIDTH   = $clog2(L1D_MASK_WIDTH);

    localparam int unsigned N_PORT_DEF  = 4;
    localparam int unsigned N_OUTST_DEF = 8;
    localparam int unsigned TAG_W_DEF   = 8;

    typedef enum logic [LDU_OP_WIDTH-1:0] {
        LduLb  = 4'd0,
        LduLh  = 4'd1,
        LduLw  = 4'd2,
        LduLd  = 4'd3,
        LduLbu = 4'd4,
        LduLhu = 4'd5,
        LduLwu = 4'd6
    } ldu_op_e;

    // Size mask from the opcode, placed at the line offset; bytes past the line are dropped.
    function automatic logic [L1D_MASK_WIDTH-1:0] rvh_l1d_dec_ld_mask(
        input logic [LDU_OP_WIDTH-1:0]     opcode,
        input logic [L1D_OFFSET_WIDTH-1:0] offset
    );
        logic [L1D_MASK_WIDTH-1:0] size_mask;
        case (opcode)
            LduLb, LduLbu: size_mask = L1D_MASK_WIDTH'(8'h01);
            LduLh, LduLhu: size_mask = L1D_MASK_WIDTH'(8'h03);
            LduLw, LduLwu: size_mask = L1D_MASK_WIDTH'(8'h0F);
            LduLd:         size_mask = L1D_MASK_WIDTH'(8'hFF);
            default:       size_mask = '0;
        endcase
        return size_mask << offset;
    endfunction

endpackage

// File: rtl/rrv2rvh_ruby_rr_arb.sv
// Round-robin arbiter: grants the first requester at or after the pointer; the pointer
// moves past the winner only when the grant is consumed.
module rrv2rvh_ruby_rr_arb #(
    parameter int unsigned N_PORT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_PORT-1:0]         req_i,
    input  logic                      advance_i,
    output logic [N_PORT-1:0]         gnt_o,
    output logic [$clog2(N_PORT)-1:0] gnt_idx_o
);
    localparam int unsigned PORT_W = $clog2(N_PORT);

    logic [PORT_W-1:0] r_ptr;
    logic [PORT_W-1:0] w_cand;
    logic              w_found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = r_ptr;
        w_cand    = r_ptr;
        w_found   = 1'b0;
        for (int unsigned i = 0; i < N_PORT; i++) begin
            w_cand = PORT_W'((32'(r_ptr) + i) % N_PORT);
            if (!w_found && req_i[w_cand]) begin
                w_found        = 1'b1;
                gnt_o[w_cand]  = 1'b1;
                gnt_idx_o      = w_cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (advance_i) begin
            r_ptr <= (32'(gnt_idx_o) == N_PORT - 1) ? '0 : gnt_idx_o + 1'b1;
        end
    end

endmodule

// File: rtl/rrv2rvh_ruby_ld_sched.sv
// Shares the single rvh L1D load port among ruby load requesters: per-port buffers,
// round-robin issue, an outstanding table and routing of responses back to the requester.
module rrv2rvh_ruby_ld_sched
    import rrv2rvh_ruby_ld_sched_pkg::*;
#(
    parameter int unsigned N_PORT   = N_PORT_DEF,
    parameter int unsigned N_OUTST  = N_OUTST_DEF,
    parameter int unsigned TAG_W    = TAG_W_DEF,
    localparam int unsigned OUTST_W = $clog2(N_OUTST)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [N_PORT-1:0]                   ruby_req_vld_i,
    output logic [N_PORT-1:0]                   ruby_req_rdy_o,
    input  logic [N_PORT*LDU_OP_WIDTH-1:0]      ruby_req_opcode_i,
    input  logic [N_PORT*PADDR_WIDTH-1:0]       ruby_req_paddr_i,
    input  logic [N_PORT*TAG_W-1:0]             ruby_req_tag_i,
    output logic                                l1d_req_vld_o,
    input  logic                                l1d_req_rdy_i,
    output logic [LDU_OP_WIDTH-1:0]             l1d_req_opcode_o,
    output logic [PADDR_WIDTH-1:0]              l1d_req_paddr_o,
    output logic [OUTST_W-1:0]                  l1d_req_id_o,
    output logic [L1D_STB_DATA_WIDTH/8-1:0]     l1d_req_mask_o,
    input  logic                                l1d_resp_vld_i,
    input  logic [OUTST_W-1:0]                  l1d_resp_id_i,
    input  logic [L1D_STB_DATA_WIDTH-1:0]       l1d_resp_data_i,
    output logic [N_PORT-1:0]                   ruby_resp_vld_o,
    output logic [TAG_W-1:0]                    ruby_resp_tag_o,
    output logic [L1D_STB_DATA_WIDTH-1:0]       ruby_resp_data_o,
    output logic [OUTST_W:0]                    outst_cnt_o,
    output logic                                err_sticky_o
);
    localparam int unsigned PORT_W = $clog2(N_PORT);
    localparam int unsigned CNT_W  = OUTST_W + 1;

    typedef struct packed {
        logic [PORT_W-1:0] port;
        logic [TAG_W-1:0]  tag;
    } ruby_ld_outst_entry_t;

    typedef struct packed {
        logic [LDU_OP_WIDTH-1:0] opcode;
        logic [PADDR_WIDTH-1:0]  paddr;
        logic [TAG_W-1:0]        tag;
    } ruby_ld_buf_t;

    logic [N_PORT-1:0]          r_buf_vld;
    ruby_ld_buf_t               r_buf [N_PORT];
    logic [N_OUTST-1:0]         r_ent_vld;
    ruby_ld_outst_entry_t       r_ent [N_OUTST];
    logic [CNT_W-1:0]           r_cnt;
    logic [N_PORT-1:0]          r_resp_vld;
    logic [TAG_W-1:0]           r_resp_tag;
    logic [L1D_STB_DATA_WIDTH-1:0] r_resp_data;
    logic                       r_err;

    logic                       w_full;
    logic [N_PORT-1:0]          w_elig;
    logic [N_PORT-1:0]          w_gnt;
    logic [PORT_W-1:0]          w_gnt_idx;
    logic                       w_hs;
    logic                       w_rel;
    logic [OUTST_W-1:0]         w_free_id;
    logic                       w_free_found;

    assign w_full = &r_ent_vld;
    assign w_elig = r_buf_vld & {N_PORT{~w_full}};
    assign w_hs   = l1d_req_vld_o & l1d_req_rdy_i;
    assign w_rel  = l1d_resp_vld_i & r_ent_vld[l1d_resp_id_i];

    rrv2rvh_ruby_rr_arb #(
        .N_PORT (N_PORT)
    ) u_rr_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (w_elig),
        .advance_i (w_hs),
        .gnt_o     (w_gnt),
        .gnt_idx_o (w_gnt_idx)
    );

    // Lowest free entry, computed from current state so an entry freed this cycle is not reused.
    always_comb begin
        w_free_id    = '0;
        w_free_found = 1'b0;
        for (int unsigned i = 0; i < N_OUTST; i++) begin
            if (!w_free_found && !r_ent_vld[i]) begin
                w_free_found = 1'b1;
                w_free_id    = OUTST_W'(i);
            end
        end
    end

    assign ruby_req_rdy_o   = ~r_buf_vld | (w_gnt & {N_PORT{w_hs}});
    assign l1d_req_vld_o    = |w_elig;
    assign l1d_req_opcode_o = r_buf[w_gnt_idx].opcode;
    assign l1d_req_paddr_o  = r_buf[w_gnt_idx].paddr;
    assign l1d_req_id_o     = w_free_id;
    assign l1d_req_mask_o   = rvh_l1d_dec_ld_mask(r_buf[w_gnt_idx].opcode,
                                                  r_buf[w_gnt_idx].paddr[L1D_OFFSET_WIDTH-1:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf_vld <= '0;
            for (int unsigned p = 0; p < N_PORT; p++) r_buf[p] <= '0;
        end else begin
            for (int unsigned p = 0; p < N_PORT; p++) begin
                if (ruby_req_vld_i[p] && ruby_req_rdy_o[p]) begin
                    r_buf_vld[p]    <= 1'b1;
                    r_buf[p].opcode <= ruby_req_opcode_i[p*LDU_OP_WIDTH +: LDU_OP_WIDTH];
                    r_buf[p].paddr  <= ruby_req_paddr_i[p*PADDR_WIDTH +: PADDR_WIDTH];
                    r_buf[p].tag    <= ruby_req_tag_i[p*TAG_W +: TAG_W];
                end else if (w_gnt[p] && w_hs) begin
                    r_buf_vld[p] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ent_vld   <= '0;
            for (int unsigned i = 0; i < N_OUTST; i++) r_ent[i] <= '0;
            r_cnt       <= '0;
            r_resp_vld  <= '0;
            r_resp_tag  <= '0;
            r_resp_data <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_hs) begin
                r_ent_vld[w_free_id] <= 1'b1;
                r_ent[w_free_id]     <= '{port: w_gnt_idx, tag: r_buf[w_gnt_idx].tag};
            end
            if (w_rel) r_ent_vld[l1d_resp_id_i] <= 1'b0;
            r_cnt <= r_cnt + CNT_W'(w_hs) - CNT_W'(w_rel);

            r_resp_vld <= '0;
            if (w_rel) begin
                r_resp_vld[r_ent[l1d_resp_id_i].port] <= 1'b1;
                r_resp_tag  <= r_ent[l1d_resp_id_i].tag;
                r_resp_data <= l1d_resp_data_i;
            end
            if (l1d_resp_vld_i && !r_ent_vld[l1d_resp_id_i]) r_err <= 1'b1;
        end
    end

    assign ruby_resp_vld_o  = r_resp_vld;
    assign ruby_resp_tag_o  = r_resp_tag;
    assign ruby_resp_data_o = r_resp_data;
    assign outst_cnt_o      = r_cnt;
    assign err_sticky_o     = r_err;

endmodule

// File: tb/tb_rrv2rvh_ruby_ld_sched.sv
// Bench for rrv2rvh_ruby_ld_sched: table-driven issue vectors, hand sequences for stall,
// full, simultaneous alloc/free and reset, and a response scoreboard.
module tb_rrv2rvh_ruby_ld_sched;
    import rrv2rvh_ruby_ld_sched_pkg::*;

    localparam int unsigned NP = 4;
    localparam int unsigned NO = 8;
    localparam int unsigned TW = 8;
    localparam int unsigned OW = 3;
    localparam int unsigned DW = L1D_STB_DATA_WIDTH;
    localparam int unsigned MW = L1D_MASK_WIDTH;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NP-1:0]              ruby_req_vld_i;
    logic [NP-1:0]              ruby_req_rdy_o;
    logic [NP*LDU_OP_WIDTH-1:0] ruby_req_opcode_i;
    logic [NP*PADDR_WIDTH-1:0]  ruby_req_paddr_i;
    logic [NP*TW-1:0]           ruby_req_tag_i;
    logic                       l1d_req_vld_o;
    logic                       l1d_req_rdy_i;
    logic [LDU_OP_WIDTH-1:0]    l1d_req_opcode_o;
    logic [PADDR_WIDTH-1:0]     l1d_req_paddr_o;
    logic [OW-1:0]              l1d_req_id_o;
    logic [MW-1:0]              l1d_req_mask_o;
    logic                       l1d_resp_vld_i;
    logic [OW-1:0]              l1d_resp_id_i;
    logic [DW-1:0]              l1d_resp_data_i;
    logic [NP-1:0]              ruby_resp_vld_o;
    logic [TW-1:0]              ruby_resp_tag_o;
    logic [DW-1:0]              ruby_resp_data_o;
    logic [OW:0]                outst_cnt_o;
    logic                       err_sticky_o;

    rrv2rvh_ruby_ld_sched #(
        .N_PORT  (NP),
        .N_OUTST (NO),
        .TAG_W   (TW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .ruby_req_vld_i    (ruby_req_vld_i),
        .ruby_req_rdy_o    (ruby_req_rdy_o),
        .ruby_req_opcode_i (ruby_req_opcode_i),
        .ruby_req_paddr_i  (ruby_req_paddr_i),
        .ruby_req_tag_i    (ruby_req_tag_i),
        .l1d_req_vld_o     (l1d_req_vld_o),
        .l1d_req_rdy_i     (l1d_req_rdy_i),
        .l1d_req_opcode_o  (l1d_req_opcode_o),
        .l1d_req_paddr_o   (l1d_req_paddr_o),
        .l1d_req_id_o      (l1d_req_id_o),
        .l1d_req_mask_o    (l1d_req_mask_o),
        .l1d_resp_vld_i    (l1d_resp_vld_i),
        .l1d_resp_id_i     (l1d_resp_id_i),
        .l1d_resp_data_i   (l1d_resp_data_i),
        .ruby_resp_vld_o   (ruby_resp_vld_o),
        .ruby_resp_tag_o   (ruby_resp_tag_o),
        .ruby_resp_data_o  (ruby_resp_data_o),
        .outst_cnt_o       (outst_cnt_o),
        .err_sticky_o      (err_sticky_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         port;
        logic [3:0] op;
        logic [5:0] off;
        logic [7:0] tag;
        logic [63:0] mask;
    } vec_t;

    typedef struct {
        logic [3:0]   vld;
        logic [7:0]   tag;
        logic [511:0] data;
        int           due;
    } exp_t;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    exp_t sb_q[$];
    exp_t e_cur;
    logic       m_vld [NO];
    int         m_port[NO];
    logic [7:0] m_tag [NO];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [55:0] mk_paddr(input int p, input logic [5:0] off);
        return 56'h40_0000 + (56'(p) << 12) + 56'(off);
    endfunction

    function automatic logic [511:0] mk_data(input int id);
        logic [31:0] w;
        w = 32'hD0D0_0000 + 32'(id * 17);
        return {16{w}};
    endfunction

    function automatic int low_free();
        for (int i = 0; i < NO; i++) if (!m_vld[i]) return i;
        return -1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_port(input int p, input logic [3:0] op, input logic [55:0] pa,
                              input logic [7:0] tag);
        ruby_req_vld_i[p]                  = 1'b1;
        ruby_req_opcode_i[p*4 +: 4]        = op;
        ruby_req_paddr_i[p*56 +: 56]       = pa;
        ruby_req_tag_i[p*8 +: 8]           = tag;
    endtask

    // Called at the negedge of a cycle expected to carry an L1D handshake.
    task automatic record_issue(input int exp_id, input int p, input logic [7:0] tag);
        check("issue_vld", l1d_req_vld_o, 1'b1);
        check("issue_id", l1d_req_id_o, exp_id);
        m_vld[exp_id]  = 1'b1;
        m_port[exp_id] = p;
        m_tag[exp_id]  = tag;
    endtask

    task automatic resp_drive(input int id, input logic [511:0] data);
        l1d_resp_vld_i  = 1'b1;
        l1d_resp_id_i   = OW'(id);
        l1d_resp_data_i = data;
        if (m_vld[id]) begin
            sb_q.push_back('{vld: 4'(1 << m_port[id]), tag: m_tag[id], data: data, due: cyc + 1});
            m_vld[id] = 1'b0;
        end
    endtask

    task automatic send_resp(input int id);
        resp_drive(id, mk_data(id));
        step();
        l1d_resp_vld_i = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e_cur = sb_q.pop_front();
            check("resp_vld", ruby_resp_vld_o, e_cur.vld);
            check("resp_tag", ruby_resp_tag_o, e_cur.tag);
            check("resp_data", ruby_resp_data_o, e_cur.data);
        end else if (ruby_resp_vld_o !== '0) begin
            check("spurious_resp", ruby_resp_vld_o, '0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    vec_t va[4];
    vec_t vc[8];
    int   seq_b[6];
    logic [55:0] pa_b[4];
    logic [7:0]  tag_b[4];
    int   exp_id;

    initial begin
        va[0] = '{0, LduLb, 6'd0, 8'h10, 64'h1};
        va[1] = '{1, LduLh, 6'd2, 8'h11, 64'hC};
        va[2] = '{2, LduLw, 6'd4, 8'h12, 64'hF0};
        va[3] = '{3, LduLd, 6'd8, 8'h13, 64'hFF00};
        vc[0] = '{0, LduLb,  6'd5,  8'h40, 64'h20};
        vc[1] = '{1, LduLhu, 6'd6,  8'h41, 64'hC0};
        vc[2] = '{3, LduLw,  6'd12, 8'h5A, 64'hF000};
        vc[3] = '{2, LduLd,  6'd60, 8'h43, 64'hF000_0000_0000_0000};
        vc[4] = '{0, LduLwu, 6'd62, 8'h44, 64'hC000_0000_0000_0000};
        vc[5] = '{1, LduLh,  6'd63, 8'h45, 64'h8000_0000_0000_0000};
        vc[6] = '{2, LduLbu, 6'd0,  8'h46, 64'h1};
        vc[7] = '{3, 4'hF,   6'd3,  8'h47, 64'h0};
        seq_b = '{1, 3, 1, 3, 1, 3};
        pa_b[1] = mk_paddr(1, 6'd4);
        pa_b[3] = mk_paddr(3, 6'd2);
        tag_b[1] = 8'h21;
        tag_b[3] = 8'h23;
        for (int i = 0; i < NO; i++) m_vld[i] = 1'b0;

        rst = 1'b0;
        ruby_req_vld_i = '0;
        ruby_req_opcode_i = '0;
        ruby_req_paddr_i = '0;
        ruby_req_tag_i = '0;
        l1d_req_rdy_i = 1'b0;
        l1d_resp_vld_i = 1'b0;
        l1d_resp_id_i = '0;
        l1d_resp_data_i = '0;

        // Reset state
        @(negedge clk);
        check("rst_l1d_vld", l1d_req_vld_o, 1'b0);
        check("rst_cnt", outst_cnt_o, 0);
        check("rst_err", err_sticky_o, 1'b0);
        check("rst_resp_vld", ruby_resp_vld_o, 4'h0);
        step();
        rst = 1'b1;
        @(negedge clk);
        check("rst_rdy", ruby_req_rdy_o, 4'hF);

        // All four ports at once: round-robin grants 0..3
        step();
        l1d_req_rdy_i = 1'b1;
        for (int p = 0; p < 4; p++) drive_port(p, va[p].op, mk_paddr(p, va[p].off), va[p].tag);
        step();
        ruby_req_vld_i = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("a_opcode", l1d_req_opcode_o, va[i].op);
            check("a_paddr", l1d_req_paddr_o, mk_paddr(va[i].port, va[i].off));
            check("a_mask", l1d_req_mask_o, va[i].mask);
            record_issue(low_free(), va[i].port, va[i].tag);
            step();
        end
        @(negedge clk);
        check("a_idle", l1d_req_vld_o, 1'b0);
        check("a_cnt", outst_cnt_o, 4);
        step();
        send_resp(3);
        send_resp(0);
        send_resp(2);
        send_resp(1);
        step();
        @(negedge clk);
        check("a_cnt_drain", outst_cnt_o, 0);

        // Ports 1 and 3 continuous, L1D stalled 3 cycles then alternating grants
        step();
        l1d_req_rdy_i = 1'b0;
        drive_port(1, LduLw, pa_b[1], tag_b[1]);
        drive_port(3, LduLh, pa_b[3], tag_b[3]);
        step();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("b_stall_vld", l1d_req_vld_o, 1'b1);
            check("b_stall_paddr", l1d_req_paddr_o, pa_b[1]);
            check("b_stall_op", l1d_req_opcode_o, LduLw);
            step();
        end
        l1d_req_rdy_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("b_rr_paddr", l1d_req_paddr_o, pa_b[seq_b[k]]);
            record_issue(low_free(), seq_b[k], tag_b[seq_b[k]]);
            step();
            if (k == 3) ruby_req_vld_i = '0;
        end
        @(negedge clk);
        check("b_idle", l1d_req_vld_o, 1'b0);
        check("b_cnt", outst_cnt_o, 6);
        step();
        for (int i = 5; i >= 0; i--) send_resp(i);

        // One request at a time from the table until the outstanding table is full
        for (int i = 0; i < 8; i++) begin
            drive_port(vc[i].port, vc[i].op, mk_paddr(vc[i].port, vc[i].off), vc[i].tag);
            step();
            ruby_req_vld_i = '0;
            @(negedge clk);
            check("c_mask", l1d_req_mask_o, vc[i].mask);
            check("c_paddr", l1d_req_paddr_o, mk_paddr(vc[i].port, vc[i].off));
            record_issue(low_free(), vc[i].port, vc[i].tag);
            step();
        end
        @(negedge clk);
        check("full_cnt", outst_cnt_o, 8);
        step();
        drive_port(0, LduLb, mk_paddr(0, 6'd1), 8'h77);
        step();
        ruby_req_vld_i = '0;
        @(negedge clk);
        check("full_no_vld", l1d_req_vld_o, 1'b0);
        check("full_rdy_drop", ruby_req_rdy_o[0], 1'b0);
        step();
        send_resp(5);
        @(negedge clk);
        check("reuse_id5", l1d_req_id_o, 5);
        record_issue(low_free(), 0, 8'h77);
        step();

        // Free 6, then allocate into 6 while entry 2 (port 3, tag 0x5A) is released
        drive_port(1, LduLd, mk_paddr(1, 6'd8), 8'h66);
        resp_drive(6, mk_data(6));
        step();
        ruby_req_vld_i = '0;
        exp_id = low_free();
        resp_drive(2, mk_data(2));
        @(negedge clk);
        check("simul_id_not2", (l1d_req_id_o != 3'd2), 1'b1);
        record_issue(exp_id, 1, 8'h66);
        step();
        l1d_resp_vld_i = 1'b0;
        @(negedge clk);
        check("simul_resp_port", ruby_resp_vld_o, 4'b1000);
        check("simul_cnt", outst_cnt_o, 7);
        check("err_clear", err_sticky_o, 1'b0);

        // Response to a free entry is dropped and flagged
        step();
        send_resp(2);
        @(negedge clk);
        check("inval_err", err_sticky_o, 1'b1);
        check("inval_cnt", outst_cnt_o, 7);

        // Reset in the middle of traffic
        step();
        drive_port(0, LduLw, mk_paddr(0, 6'd0), 8'h90);
        drive_port(2, LduLh, mk_paddr(2, 6'd2), 8'h92);
        step();
        step();
        rst = 1'b0;
        ruby_req_vld_i = '0;
        #2;
        check("mid_rst_vld", l1d_req_vld_o, 1'b0);
        check("mid_rst_cnt", outst_cnt_o, 0);
        check("mid_rst_err", err_sticky_o, 1'b0);
        check("mid_rst_resp", ruby_resp_vld_o, 4'h0);
        check("mid_rst_rdy", ruby_req_rdy_o, 4'hF);
        for (int i = 0; i < NO; i++) m_vld[i] = 1'b0;
        step();
        rst = 1'b1;
        step();
        send_resp(0);
        @(negedge clk);
        check("late_resp_err", err_sticky_o, 1'b1);
        check("late_resp_none", ruby_resp_vld_o, 4'h0);

        step();
        check("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
